// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file and the
// decode/writeback stages that slice its flattened port vectors.
package regfile_pkg;

  function automatic int aw_of(input int nregs);
    return (nregs <= 2) ? 1 : $clog2(nregs);
  endfunction

  localparam int DEF_XLEN  = 32;
  localparam int DEF_NREGS = 32;
  localparam int DEF_NRD   = 2;
  localparam int DEF_NWR   = 1;
  localparam int DEF_AW    = aw_of(DEF_NREGS);

  // Flattened port widths for the default core configuration
  localparam int RA_W = DEF_NRD * DEF_AW;
  localparam int RD_W = DEF_NRD * DEF_XLEN;
  localparam int WA_W = DEF_NWR * DEF_AW;
  localparam int WD_W = DEF_NWR * DEF_XLEN;

endpackage

// File: rtl/regfile_mp_if.sv
// Decode/writeback <-> register file bus. Packed [port][bits] arrays keep
// port i at bits [i*W +: W] of the flattened view.
interface regfile_mp_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  parameter int NWR   = 1
);
  localparam int AW = regfile_pkg::aw_of(NREGS);

  logic [NRD-1:0][AW-1:0]   ra;
  logic [NRD-1:0][XLEN-1:0] rd;
  logic [NRD-1:0]           rbusy;
  logic [NWR-1:0]           we;
  logic [NWR-1:0][AW-1:0]   wa;
  logic [NWR-1:0][XLEN-1:0] wd;
  logic                     busy_set;
  logic [AW-1:0]            busy_addr;
  logic [NREGS-1:0]         busy;

  modport master (output ra, we, wa, wd, busy_set, busy_addr,
                  input  rd, rbusy, busy);
  modport slave  (input  ra, we, wa, wd, busy_set, busy_addr,
                  output rd, rbusy, busy);
endinterface

// File: rtl/regfile_rdport.sv
// One read port: array mux, write bypass (highest port wins), zero-register
// masking and an optional output register.
module regfile_rdport import regfile_pkg::*; #(
  parameter int  XLEN     = 32,
  parameter int  NREGS    = 32,
  parameter int  NWR      = 1,
  parameter bit  BYPASS   = 1'b1,
  parameter bit  RD_REG   = 1'b0,
  parameter bit  ZERO_REG = 1'b1,
  localparam int AW       = aw_of(NREGS)
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [AW-1:0]             ra,
  input  logic [NREGS-1:0][XLEN-1:0] rf,
  input  logic [NREGS-1:0]          busy,
  input  logic [NWR-1:0]            we,
  input  logic [NWR-1:0][AW-1:0]    wa,
  input  logic [NWR-1:0][XLEN-1:0]  wd,
  output logic [XLEN-1:0]           rd,
  output logic                      rbusy
);

  logic [XLEN-1:0] rd_c, rd_q;
  logic            rb_c, rb_q;

  always_comb begin
    rd_c = rf[ra];
    rb_c = busy[ra];
    if (BYPASS) begin
      for (int j = 0; j < NWR; j++) begin
        if (we[j] && (wa[j] == ra)) begin
          rd_c = wd[j];
          rb_c = 1'b0;
        end
      end
    end
    if (ZERO_REG && (ra == '0)) begin
      rd_c = '0;
      rb_c = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_q <= '0;
      rb_q <= 1'b0;
    end else begin
      rd_q <= rd_c;
      rb_q <= rb_c;
    end
  end

  // Output flop is simply left unloaded when reads are combinational
  assign rd    = RD_REG ? rd_q : rd_c;
  assign rbusy = RD_REG ? rb_q : rb_c;

endmodule

// File: rtl/regfile_mp.sv
// Parameterised multi-port integer register file with hardwired zero
// register and a busy-bit scoreboard for the hazard unit.
module regfile_mp import regfile_pkg::*; #(
  parameter int XLEN     = DEF_XLEN,
  parameter int NREGS    = DEF_NREGS,
  parameter int NRD      = DEF_NRD,
  parameter int NWR      = DEF_NWR,
  parameter bit BYPASS   = 1'b1,
  parameter bit RD_REG   = 1'b0,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic         clk,
  input  logic         resetn,
  regfile_mp_if.slave  bus
);

  logic [NREGS-1:0][XLEN-1:0] rf;
  logic [NREGS-1:0]           busy_q;
  logic [NRD-1:0][XLEN-1:0]   rd_w;
  logic [NRD-1:0]             rbusy_w;

  // Later ports are assigned last, so the highest index wins a collision
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rf <= '0;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (bus.we[j] && !(ZERO_REG && (bus.wa[j] == '0)))
          rf[bus.wa[j]] <= bus.wd[j];
      end
    end
  end

  // Set is applied after clears: a new producer supersedes the retiring one
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      busy_q <= '0;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (bus.we[j]) busy_q[bus.wa[j]] <= 1'b0;
      end
      if (bus.busy_set) busy_q[bus.busy_addr] <= 1'b1;
      if (ZERO_REG) busy_q[0] <= 1'b0;
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    regfile_rdport #(
      .XLEN(XLEN), .NREGS(NREGS), .NWR(NWR),
      .BYPASS(BYPASS), .RD_REG(RD_REG), .ZERO_REG(ZERO_REG)
    ) u_rd (
      .clk    (clk),
      .resetn (resetn),
      .ra     (bus.ra[i]),
      .rf     (rf),
      .busy   (busy_q),
      .we     (bus.we),
      .wa     (bus.wa),
      .wd     (bus.wd),
      .rd     (rd_w[i]),
      .rbusy  (rbusy_w[i])
    );
  end

  assign bus.rd    = rd_w;
  assign bus.rbusy = rbusy_w;
  assign bus.busy  = busy_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench: three regfile_mp configs (bypass/comb, no-bypass/comb,
// bypass/registered) driven by one shared vector table.
module tb_regfile_mp;

  logic clk = 1'b0;
  logic clk_en = 1'b0;
  logic resetn = 1'b0;

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  logic [1:0][4:0]  ra;
  logic [1:0]       we;
  logic [1:0][4:0]  wa;
  logic [1:0][31:0] wd;
  logic             busy_set;
  logic [4:0]       busy_addr;

  regfile_mp_if #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2)) ifa ();
  regfile_mp_if #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2)) ifb ();
  regfile_mp_if #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2)) ifc ();

  assign ifa.ra = ra;  assign ifa.we = we;  assign ifa.wa = wa;  assign ifa.wd = wd;
  assign ifa.busy_set = busy_set;  assign ifa.busy_addr = busy_addr;
  assign ifb.ra = ra;  assign ifb.we = we;  assign ifb.wa = wa;  assign ifb.wd = wd;
  assign ifb.busy_set = busy_set;  assign ifb.busy_addr = busy_addr;
  assign ifc.ra = ra;  assign ifc.we = we;  assign ifc.wa = wa;  assign ifc.wd = wd;
  assign ifc.busy_set = busy_set;  assign ifc.busy_addr = busy_addr;

  regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2),
               .BYPASS(1'b1), .RD_REG(1'b0), .ZERO_REG(1'b1))
    dut_a (.clk(clk), .resetn(resetn), .bus(ifa));
  regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2),
               .BYPASS(1'b0), .RD_REG(1'b0), .ZERO_REG(1'b1))
    dut_b (.clk(clk), .resetn(resetn), .bus(ifb));
  regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2),
               .BYPASS(1'b1), .RD_REG(1'b1), .ZERO_REG(1'b1))
    dut_c (.clk(clk), .resetn(resetn), .bus(ifc));

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    logic [4:0]  ra0, ra1;
    logic        bs;
    logic [4:0]  ba;
    logic [31:0] e0, e1;     // bypass on, combinational
    logic        eb0, eb1;
    logic [31:0] n0, n1;     // bypass off
    logic        nb0, nb1;
    logic [31:0] ebusy;      // scoreboard before the edge
  } vec_t;

  localparam int NV = 18;
  vec_t tbl [NV];

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  function automatic vec_t mk(
    input logic [1:0] we_, input logic [4:0] wa0_, wa1_, input logic [31:0] wd0_, wd1_,
    input logic [4:0] ra0_, ra1_, input logic bs_, input logic [4:0] ba_,
    input logic [31:0] e0_, e1_, input logic eb0_, eb1_,
    input logic [31:0] n0_, n1_, input logic nb0_, nb1_, input logic [31:0] ebusy_);
    vec_t v;
    v.we = we_; v.wa0 = wa0_; v.wa1 = wa1_; v.wd0 = wd0_; v.wd1 = wd1_;
    v.ra0 = ra0_; v.ra1 = ra1_; v.bs = bs_; v.ba = ba_;
    v.e0 = e0_; v.e1 = e1_; v.eb0 = eb0_; v.eb1 = eb1_;
    v.n0 = n0_; v.n1 = n1_; v.nb0 = nb0_; v.nb1 = nb1_; v.ebusy = ebusy_;
    return v;
  endfunction

  logic [31:0] prev0, prev1;
  logic        prevb0, prevb1;

  initial begin
    //                we    wa0 wa1 wd0           wd1   ra0 ra1 bs ba  e0            e1            eb0 eb1 n0            n1            nb0 nb1 busy
    tbl[0]  = mk(2'b00, 0, 0, 32'h0,        32'h0, 5, 31, 0, 0, 32'h0,        32'h0,        0, 0, 32'h0,        32'h0,        0, 0, 32'h0);
    tbl[1]  = mk(2'b01, 3, 0, 32'hDEADBEEF, 32'h0, 3, 0,  0, 0, 32'hDEADBEEF, 32'h0,        0, 0, 32'h0,        32'h0,        0, 0, 32'h0);
    tbl[2]  = mk(2'b00, 0, 0, 32'h0,        32'h0, 3, 5,  0, 0, 32'hDEADBEEF, 32'h0,        0, 0, 32'hDEADBEEF, 32'h0,        0, 0, 32'h0);
    tbl[3]  = mk(2'b01, 0, 0, 32'h1234,     32'h0, 0, 3,  0, 0, 32'h0,        32'hDEADBEEF, 0, 0, 32'h0,        32'hDEADBEEF, 0, 0, 32'h0);
    tbl[4]  = mk(2'b00, 0, 0, 32'h0,        32'h0, 0, 3,  0, 0, 32'h0,        32'hDEADBEEF, 0, 0, 32'h0,        32'hDEADBEEF, 0, 0, 32'h0);
    tbl[5]  = mk(2'b01, 7, 0, 32'hA5A5A5A5, 32'h0, 3, 7,  0, 0, 32'hDEADBEEF, 32'hA5A5A5A5, 0, 0, 32'hDEADBEEF, 32'h0,        0, 0, 32'h0);
    tbl[6]  = mk(2'b11, 9, 9, 32'h1,        32'h2, 9, 7,  0, 0, 32'h2,        32'hA5A5A5A5, 0, 0, 32'h0,        32'hA5A5A5A5, 0, 0, 32'h0);
    tbl[7]  = mk(2'b00, 0, 0, 32'h0,        32'h0, 9, 7,  0, 0, 32'h2,        32'hA5A5A5A5, 0, 0, 32'h2,        32'hA5A5A5A5, 0, 0, 32'h0);
    tbl[8]  = mk(2'b00, 0, 0, 32'h0,        32'h0, 4, 9,  1, 4, 32'h0,        32'h2,        0, 0, 32'h0,        32'h2,        0, 0, 32'h0);
    tbl[9]  = mk(2'b00, 0, 0, 32'h0,        32'h0, 4, 9,  0, 0, 32'h0,        32'h2,        1, 0, 32'h0,        32'h2,        1, 0, 32'h10);
    tbl[10] = mk(2'b01, 4, 0, 32'h44,       32'h0, 4, 4,  0, 0, 32'h44,       32'h44,       0, 0, 32'h0,        32'h0,        1, 1, 32'h10);
    tbl[11] = mk(2'b00, 0, 0, 32'h0,        32'h0, 4, 9,  0, 0, 32'h44,       32'h2,        0, 0, 32'h44,       32'h2,        0, 0, 32'h0);
    tbl[12] = mk(2'b01, 4, 0, 32'h55,       32'h0, 4, 4,  1, 4, 32'h55,       32'h55,       0, 0, 32'h44,       32'h44,       0, 0, 32'h0);
    tbl[13] = mk(2'b00, 0, 0, 32'h0,        32'h0, 4, 3,  0, 0, 32'h55,       32'hDEADBEEF, 1, 0, 32'h55,       32'hDEADBEEF, 1, 0, 32'h10);
    tbl[14] = mk(2'b00, 0, 0, 32'h0,        32'h0, 0, 4,  1, 0, 32'h0,        32'h55,       0, 1, 32'h0,        32'h55,       0, 1, 32'h10);
    tbl[15] = mk(2'b00, 0, 0, 32'h0,        32'h0, 0, 4,  0, 0, 32'h0,        32'h55,       0, 1, 32'h0,        32'h55,       0, 1, 32'h10);
    tbl[16] = mk(2'b10, 0, 4, 32'h0,        32'h66, 4, 9, 0, 0, 32'h66,       32'h2,        0, 0, 32'h55,       32'h2,        1, 0, 32'h10);
    tbl[17] = mk(2'b00, 0, 0, 32'h0,        32'h0, 4, 0,  0, 0, 32'h66,       32'h0,        0, 0, 32'h66,       32'h0,        0, 0, 32'h0);

    ra = '0; ra[0] = 5'd5; ra[1] = 5'd31;
    we = '0; wa = '0; wd = '0; busy_set = 1'b0; busy_addr = '0;

    // Reset with the clock stopped: outputs must clear without any edge
    #3;
    chk("rst_a_rd0", ifa.rd[0], 32'h0);
    chk("rst_a_rd1", ifa.rd[1], 32'h0);
    chk("rst_a_busy", ifa.busy, 32'h0);
    chk("rst_c_rd0", ifc.rd[0], 32'h0);
    #1;
    resetn = 1'b1;
    clk_en = 1'b1;
    @(negedge clk);

    prev0 = '0; prev1 = '0; prevb0 = 1'b0; prevb1 = 1'b0;
    for (int i = 0; i < NV; i++) begin
      we = tbl[i].we;
      wa[0] = tbl[i].wa0; wa[1] = tbl[i].wa1;
      wd[0] = tbl[i].wd0; wd[1] = tbl[i].wd1;
      ra[0] = tbl[i].ra0; ra[1] = tbl[i].ra1;
      busy_set = tbl[i].bs; busy_addr = tbl[i].ba;
      #2;
      chk($sformatf("v%0d_a_rd0", i), ifa.rd[0], tbl[i].e0);
      chk($sformatf("v%0d_a_rd1", i), ifa.rd[1], tbl[i].e1);
      chk($sformatf("v%0d_a_rb0", i), {31'b0, ifa.rbusy[0]}, {31'b0, tbl[i].eb0});
      chk($sformatf("v%0d_a_rb1", i), {31'b0, ifa.rbusy[1]}, {31'b0, tbl[i].eb1});
      chk($sformatf("v%0d_a_busy", i), ifa.busy, tbl[i].ebusy);
      chk($sformatf("v%0d_b_rd0", i), ifb.rd[0], tbl[i].n0);
      chk($sformatf("v%0d_b_rd1", i), ifb.rd[1], tbl[i].n1);
      chk($sformatf("v%0d_b_rb0", i), {31'b0, ifb.rbusy[0]}, {31'b0, tbl[i].nb0});
      chk($sformatf("v%0d_b_rb1", i), {31'b0, ifb.rbusy[1]}, {31'b0, tbl[i].nb1});
      // Registered port shows what the comb/bypass path showed one cycle ago
      chk($sformatf("v%0d_c_rd0", i), ifc.rd[0], prev0);
      chk($sformatf("v%0d_c_rd1", i), ifc.rd[1], prev1);
      chk($sformatf("v%0d_c_rb0", i), {31'b0, ifc.rbusy[0]}, {31'b0, prevb0});
      chk($sformatf("v%0d_c_rb1", i), {31'b0, ifc.rbusy[1]}, {31'b0, prevb1});
      prev0 = tbl[i].e0; prev1 = tbl[i].e1; prevb0 = tbl[i].eb0; prevb1 = tbl[i].eb1;
      @(posedge clk);
      @(negedge clk);
    end

    // Mid-stream async reset with the clock held low
    clk_en = 1'b0;
    we = '0; busy_set = 1'b0;
    ra[0] = 5'd9; ra[1] = 5'd4;
    #2;
    chk("pre_a_rd0", ifa.rd[0], 32'h2);
    chk("pre_a_rd1", ifa.rd[1], 32'h66);
    chk("pre_c_rd0", ifc.rd[0], prev0);
    resetn = 1'b0;
    #1;
    chk("mid_a_rd0", ifa.rd[0], 32'h0);
    chk("mid_a_rd1", ifa.rd[1], 32'h0);
    chk("mid_a_busy", ifa.busy, 32'h0);
    chk("mid_b_rd0", ifb.rd[0], 32'h0);
    chk("mid_c_rd0", ifc.rd[0], 32'h0);
    chk("mid_c_rd1", ifc.rd[1], 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
